// File: rtl/regfile_mp_pkg.sv
// Shared widths and types for the multi-port register file.
package regfile_mp_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  typedef logic [DATA_W_DEF-1:0] data_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

  // True when two packed addresses refer to the same register.
  function automatic logic addr_match(input addr_t a, input addr_t b);
    return a == b;
  endfunction

endpackage

// File: rtl/regfile_mp_wr_decoder.sv
// One-hot decode of an address gated by an enable; drives both the write
// strobes and the scoreboard set/clear vectors.
module wr_decoder #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DEPTH-1:0]  onehot_o
);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dec
      assign onehot_o[gi] = en_i && (addr_i == ADDR_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with asynchronous reads, optional zero register,
// optional write-to-read bypass and a per-register busy scoreboard.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 1,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NWR-1:0]        we_i,
  input  logic [NWR*ADDR_W-1:0] waddr_i,
  input  logic [NWR*DATA_W-1:0] wdata_i,
  input  logic [NRD*ADDR_W-1:0] raddr_i,
  output logic [NRD*DATA_W-1:0] rdata_o,
  input  logic                  sb_set_i,
  input  logic [ADDR_W-1:0]     sb_addr_i,
  output logic [NRD-1:0]        busy_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  logic [ADDR_W-1:0] waddr [NWR];
  logic [DATA_W-1:0] wdata [NWR];
  logic [DEPTH-1:0]  wr_dec [NWR];
  logic [DEPTH-1:0]  wr_hit [NWR];
  logic [DEPTH-1:0]  sb_dec;
  logic [DEPTH-1:0]  sb_set;
  logic [DEPTH-1:0]  sb_clr;
  logic [DEPTH-1:0]  keep_mask;

  // Register 0 is excluded from every write and scoreboard strobe when hardwired.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mask
      if (gi == 0 && ZERO_REG) begin : g_zero
        assign keep_mask[gi] = 1'b0;
      end else begin : g_norm
        assign keep_mask[gi] = 1'b1;
      end
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < NWR; gi++) begin : g_wport
      assign waddr[gi] = waddr_i[gi*ADDR_W +: ADDR_W];
      assign wdata[gi] = wdata_i[gi*DATA_W +: DATA_W];

      wr_decoder #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
      ) u_wr_dec (
        .en_i     (we_i[gi]),
        .addr_i   (waddr[gi]),
        .onehot_o (wr_dec[gi])
      );

      assign wr_hit[gi] = wr_dec[gi] & keep_mask;
    end
  endgenerate

  wr_decoder #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_sb_dec (
    .en_i     (sb_set_i),
    .addr_i   (sb_addr_i),
    .onehot_o (sb_dec)
  );

  assign sb_set = sb_dec & keep_mask;

  always_comb begin
    sb_clr = '0;
    for (int p = 0; p < NWR; p++) begin
      sb_clr = sb_clr | wr_hit[p];
    end
  end

  // A fresh issue overrides a writeback from the previous producer.
  assign busy_d = (busy_q & ~sb_clr) | sb_set;

  // Later ports are applied last, so the highest index wins a collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        for (int r = 0; r < DEPTH; r++) begin
          if (wr_hit[p][r]) begin
            mem_q[r] <= wdata[p];
          end
        end
      end
      busy_q <= busy_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rport
      logic [ADDR_W-1:0] raddr;
      logic [DATA_W-1:0] rdata;
      logic              busy;

      assign raddr = raddr_i[gi*ADDR_W +: ADDR_W];

      always_comb begin
        rdata = mem_q[raddr];
        busy  = busy_q[raddr];
        if (BYPASS) begin
          for (int p = 0; p < NWR; p++) begin
            if (we_i[p] && (waddr[p] == raddr)) begin
              rdata = wdata[p];
              busy  = 1'b0;
            end
          end
        end
        if (ZERO_REG && (raddr == '0)) begin
          rdata = '0;
          busy  = 1'b0;
        end
      end

      assign rdata_o[gi*DATA_W +: DATA_W] = rdata;
      assign busy_o[gi]                   = busy;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: one DUT with bypass and zero register, one without either.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [9:0]  raddr;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic [63:0] rdata, rdata_nb;
  logic [1:0]  busy, busy_nb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .NWR(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .raddr_i(raddr), .rdata_o(rdata), .sb_set_i(sb_set), .sb_addr_i(sb_addr), .busy_o(busy)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .NWR(2), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .raddr_i(raddr), .rdata_o(rdata_nb), .sb_set_i(sb_set), .sb_addr_i(sb_addr), .busy_o(busy_nb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    we[p]          = 1'b1;
    waddr[p*5 +: 5] = a;
    wdata[p*32 +: 32] = d;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    raddr = {a1, a0};
  endtask

  initial begin
    reset = 1'b1; we = '0; waddr = '0; wdata = '0; raddr = '0; sb_set = 1'b0; sb_addr = '0;
    tick();

    // Write and issue during reset must be ignored.
    wr(0, 5'd3, 32'hA5A5A5A5);
    sb_set = 1'b1; sb_addr = 5'd3;
    tick();
    reset = 1'b0; we = '0; sb_set = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rd(5'(a), 5'(31 - a));
      settle();
      chk($sformatf("rst_rd0_a%0d", a), rdata[31:0], 32'h0);
      chk($sformatf("rst_rd1_a%0d", a), rdata[63:32], 32'h0);
      chk($sformatf("rst_busy_a%0d", a), {30'b0, busy}, 32'h0);
      chk($sformatf("rst_nb_rd0_a%0d", a), rdata_nb[31:0], 32'h0);
      chk($sformatf("rst_nb_busy_a%0d", a), {30'b0, busy_nb}, 32'h0);
      $display("reset read a=%0d done", a);
    end

    // Same-cycle write/read of r7.
    wr(0, 5'd7, 32'hDEADBEEF); rd(5'd7, 5'd3);
    settle();
    chk("byp_r7", rdata[31:0], 32'hDEADBEEF);
    chk("nobyp_r7_old", rdata_nb[31:0], 32'h0);
    tick(); we = '0;
    settle();
    chk("r7_next", rdata[31:0], 32'hDEADBEEF);
    chk("nb_r7_next", rdata_nb[31:0], 32'hDEADBEEF);
    chk("r3_after_rst", rdata[63:32], 32'h0);
    $display("r7 write/read done");

    // Writes to r0.
    wr(0, 5'd0, 32'hFFFFFFFF); rd(5'd0, 5'd0);
    settle();
    chk("zero_byp_l0", rdata[31:0], 32'h0);
    chk("zero_byp_l1", rdata[63:32], 32'h0);
    tick(); we = '0;
    settle();
    chk("zero_l0", rdata[31:0], 32'h0);
    chk("zero_l1", rdata[63:32], 32'h0);
    chk("nz_l0", rdata_nb[31:0], 32'hFFFFFFFF);
    chk("nz_l1", rdata_nb[63:32], 32'hFFFFFFFF);
    $display("r0 write done");

    // Collision on r9: port 1 wins.
    wr(0, 5'd9, 32'h11111111); wr(1, 5'd9, 32'h22222222); rd(5'd9, 5'd7);
    settle();
    chk("coll_byp", rdata[31:0], 32'h22222222);
    tick(); we = '0;
    settle();
    chk("coll_r9", rdata[31:0], 32'h22222222);
    chk("nb_coll_r9", rdata_nb[31:0], 32'h22222222);
    $display("collision r9 done");

    // Scoreboard set, then writeback on r4.
    sb_set = 1'b1; sb_addr = 5'd4; rd(5'd4, 5'd9);
    settle();
    chk("sb_same_cycle", {31'b0, busy[0]}, 32'h0);
    tick(); sb_set = 1'b0;
    settle();
    chk("sb_busy", {31'b0, busy[0]}, 32'h1);
    chk("nb_sb_busy", {31'b0, busy_nb[0]}, 32'h1);
    chk("sb_other_lane", {31'b0, busy[1]}, 32'h0);
    wr(0, 5'd4, 32'h00000042);
    settle();
    chk("wb_busy_byp", {31'b0, busy[0]}, 32'h0);
    chk("wb_busy_nb", {31'b0, busy_nb[0]}, 32'h1);
    chk("wb_rd_byp", rdata[31:0], 32'h00000042);
    tick(); we = '0;
    settle();
    chk("wb_busy_clr", {31'b0, busy[0]}, 32'h0);
    chk("nb_wb_busy_clr", {31'b0, busy_nb[0]}, 32'h0);
    chk("wb_rd", rdata[31:0], 32'h00000042);
    chk("nb_wb_rd", rdata_nb[31:0], 32'h00000042);
    $display("scoreboard r4 done");

    // Set and clear together on r5: set wins.
    sb_set = 1'b1; sb_addr = 5'd5; wr(1, 5'd5, 32'h12345678); rd(5'd4, 5'd5);
    tick(); sb_set = 1'b0; we = '0;
    settle();
    chk("setclr_busy", {31'b0, busy[1]}, 32'h1);
    chk("nb_setclr_busy", {31'b0, busy_nb[1]}, 32'h1);
    chk("setclr_rd", rdata[63:32], 32'h12345678);
    chk("nb_setclr_rd", rdata_nb[63:32], 32'h12345678);
    $display("set/clear r5 done");

    // Issue to r0: ignored only with the zero register.
    sb_set = 1'b1; sb_addr = 5'd0; rd(5'd0, 5'd5);
    tick(); sb_set = 1'b0;
    settle();
    chk("sb_r0_zero", {31'b0, busy[0]}, 32'h0);
    chk("sb_r0_nb", {31'b0, busy_nb[0]}, 32'h1);
    $display("issue r0 done");

    // Mid-stream reset drops the pending write and all state.
    reset = 1'b1; wr(0, 5'd10, 32'hCAFEF00D);
    tick(); reset = 1'b0; we = '0; rd(5'd10, 5'd5);
    settle();
    chk("mid_rst_r10", rdata[31:0], 32'h0);
    chk("mid_rst_nb_r10", rdata_nb[31:0], 32'h0);
    chk("mid_rst_r5", rdata[63:32], 32'h0);
    chk("mid_rst_busy", {31'b0, busy[1]}, 32'h0);
    chk("mid_rst_nb_busy", {31'b0, busy_nb[1]}, 32'h0);
    $display("mid-stream reset done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
